// File: rtl/ppt_pkg.sv
// Shared types and constants for the PPT pulse-train sequencer.
package ppt_pkg;
   localparam int CNT_W_DEF   = 16;
   localparam int CLK_DIV_MAX = 30;

   typedef enum logic [1:0] {IDLE, FIRE, WAIT, DONE} ppt_state_e;

   // Dividers above CLK_DIV_MAX would overflow the prescaler, so clamp them.
   function automatic logic [4:0] sat_clk_div(input logic [4:0] div);
      return (div > 5'(CLK_DIV_MAX)) ? 5'(CLK_DIV_MAX) : div;
   endfunction
endpackage

// File: rtl/ppt_sequencer_if.sv
// Register-map side bundle of the PPT sequencer: configuration in, status out.
// PPT_INHIBIT_EN adds the active-high safety interlock input 'inhibit'.
interface ppt_sequencer_if #(parameter int CNT_W = 16);
   logic [4:0]       clk_div;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] count;
   logic             run_ppt;
`ifdef PPT_INHIBIT_EN
   logic             inhibit;
`endif
   logic             ppt_out;
   logic [CNT_W-1:0] count_done;
   logic             done;
   logic             busy;

`ifdef PPT_INHIBIT_EN
   modport master (output clk_div, period, width, count, run_ppt, inhibit,
                   input  ppt_out, count_done, done, busy);
   modport slave  (input  clk_div, period, width, count, run_ppt, inhibit,
                   output ppt_out, count_done, done, busy);
`else
   modport master (output clk_div, period, width, count, run_ppt,
                   input  ppt_out, count_done, done, busy);
   modport slave  (input  clk_div, period, width, count, run_ppt,
                   output ppt_out, count_done, done, busy);
`endif
endinterface

// File: rtl/ppt_prescaler.sv
// Time-base prescaler: one-cycle tick every 2^(clk_div+1) enabled clk cycles.
module ppt_prescaler #(
   parameter int DIV_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [4:0] clk_div,
   output logic       tick
);
   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic [DIV_W-1:0] limit;

   assign limit = ({{(DIV_W-1){1'b0}}, 1'b1} << (6'(clk_div) + 6'd1)) - DIV_W'(1);
   assign tick  = en && (cnt_q == limit);
   assign cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/ppt_sequencer.sv
// PPT firing sequencer: 'count' pulses of W ticks high, repeating every P ticks.
// Build with PPT_INHIBIT_EN to add the inhibit interlock that freezes the sequence.
import ppt_pkg::*;

module ppt_sequencer #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int DIV_W = 32
) (
   input logic            clk,
   input logic            rst,
   ppt_sequencer_if.slave bus
);
   ppt_state_e       state_q;
   logic             ppt_out_q;
   logic             done_q;
   logic             busy_q;
   logic [CNT_W-1:0] count_done_q;
   logic [CNT_W-1:0] count_done_d;
   logic [CNT_W-1:0] count_q;
   logic [4:0]       div_q;
   logic [CNT_W:0]   high_q;
   logic [CNT_W:0]   low_q;
   logic [CNT_W:0]   tick_cnt_q;
   logic [CNT_W:0]   tick_cnt_d;
   logic [CNT_W-1:0] w_eff;
   logic [CNT_W-1:0] p_eff;
   logic [CNT_W-1:0] low_eff;
   logic             inhibit;
   logic             start;
   logic             run_en;
   logic             tick;

`ifdef PPT_INHIBIT_EN
   assign inhibit = bus.inhibit;
`else
   assign inhibit = 1'b0;
`endif

   // Low phase is never shorter than one tick, even when W >= P.
   assign w_eff   = (bus.width  == '0) ? CNT_W'(1) : bus.width;
   assign p_eff   = (bus.period == '0) ? CNT_W'(1) : bus.period;
   assign low_eff = (p_eff > w_eff) ? p_eff - w_eff : CNT_W'(1);

   assign start        = (state_q == IDLE) && bus.run_ppt && !inhibit;
   assign run_en       = ((state_q == FIRE) || (state_q == WAIT)) && !inhibit;
   assign tick_cnt_d   = tick_cnt_q + (CNT_W+1)'(1);
   assign count_done_d = count_done_q + CNT_W'(1);

   ppt_prescaler #(.DIV_W(DIV_W)) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .clr     (start),
      .en      (run_en),
      .clk_div (div_q),
      .tick    (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         ppt_out_q    <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         count_done_q <= '0;
         count_q      <= '0;
         div_q        <= '0;
         high_q       <= '0;
         low_q        <= '0;
         tick_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               ppt_out_q <= 1'b0;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               if (start) begin
                  div_q        <= sat_clk_div(bus.clk_div);
                  high_q       <= {1'b0, w_eff};
                  low_q        <= {1'b0, low_eff};
                  count_q      <= bus.count;
                  count_done_q <= '0;
                  tick_cnt_q   <= '0;
                  if (bus.count == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= FIRE;
                     ppt_out_q <= 1'b1;
                     busy_q    <= 1'b1;
                  end
               end
            end
            FIRE: begin
               if (!bus.run_ppt) begin
                  state_q   <= IDLE;
                  ppt_out_q <= 1'b0;
                  busy_q    <= 1'b0;
               end else if (inhibit) begin
                  ppt_out_q <= 1'b0;
               end else if (tick && (tick_cnt_d == high_q)) begin
                  state_q      <= WAIT;
                  ppt_out_q    <= 1'b0;
                  count_done_q <= count_done_d;
                  tick_cnt_q   <= '0;
               end else begin
                  ppt_out_q <= 1'b1;
                  if (tick) tick_cnt_q <= tick_cnt_d;
               end
            end
            WAIT: begin
               ppt_out_q <= 1'b0;
               if (!bus.run_ppt) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (tick && (tick_cnt_d == low_q)) begin
                  tick_cnt_q <= '0;
                  if (count_done_q == count_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q   <= FIRE;
                     ppt_out_q <= 1'b1;
                  end
               end else if (tick) begin
                  tick_cnt_q <= tick_cnt_d;
               end
            end
            DONE: begin
               ppt_out_q <= 1'b0;
               busy_q    <= 1'b0;
               if (!bus.run_ppt) begin
                  state_q <= IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ppt_out    = ppt_out_q;
   assign bus.count_done = count_done_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_q;
endmodule

// File: doc/ppt_sequencer.md
Name: ppt_sequencer

Overview:
Pulse-train sequencer for the pulsed plasma thruster (PPT) firing output, driven by the register map's PPT-side ports.
- Derives a time-base tick from `clk` via `clk_div`.
- Emits `count` pulses, each `width` ticks high, repeating every `period` ticks.
- Reports progress (`count_done`) and completion (`done`) back to the register map for I2C readback.

Parameters:
CNT_W, 16, width of period/width/count/count_done fields
DIV_W, 32, prescaler counter width; supports clk_div up to 30

Ports:
clk  input  1  system clock (32.768 kHz oscillator domain)
rst  input  1  synchronous reset, active-high
clk_div  input  5  tick period = 2^(clk_div+1) clk cycles; values >30 saturate to 30
period  input  CNT_W  pulse repetition period in ticks
width  input  CNT_W  pulse high time in ticks
count  input  CNT_W  number of pulses to fire
run_ppt  input  1  level enable; 1 = run, 0 = abort/idle
ppt_out  output  1  thruster fire pulse, registered
count_done  output  CNT_W  pulses completed, registered
done  output  1  sequence complete, registered
busy  output  1  high in FIRE or WAIT

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is synchronous, active-high. Reset forces state IDLE, ppt_out=0, count_done=0, done=0, busy=0, prescaler=0.
- Config capture: clk_div, period, width and count are latched on the start cycle. Later input changes are ignored until the next start.
- Effective values:
  - P = max(period,1).
  - W = max(width,1).
  - If W >= P, the low phase is fixed at 1 tick, so the actual repetition is W+1 ticks.
- Prescaler: cleared on start. Counts clk cycles and asserts a 1-cycle tick when it reaches 2^(clk_div+1)-1, then wraps to 0. It runs only in FIRE/WAIT.
- FSM states: IDLE, FIRE, WAIT, DONE.
- IDLE:
  - run_ppt=1 and latched count==0: go to DONE directly; ppt_out stays 0; count_done=0.
  - run_ppt=1 and count!=0: next cycle go to FIRE; ppt_out=1; count_done cleared to 0; tick counter=0.
  - This is 1-cycle latency from sampling run_ppt to ppt_out rising.
- FIRE: ppt_out=1. Counts ticks. On the W-th tick:
  - go to WAIT;
  - ppt_out=0 next cycle;
  - count_done increments in the same cycle.
- WAIT: ppt_out=0. On the tick that completes max(P-W,1) low ticks:
  - count_done == latched count: go to DONE;
  - otherwise: go to FIRE, ppt_out=1 next cycle.
- DONE: done=1, ppt_out=0, busy=0. count_done holds its final value. Stays in DONE until run_ppt=0, then goes to IDLE and done clears. count_done is retained until the next start.
- Abort: run_ppt=0 in FIRE or WAIT means the next cycle is IDLE with ppt_out=0. count_done keeps the partial value; done stays 0. The abort has priority over a tick in the same cycle.
- Arithmetic: count_done never wraps, since count ≤ 2^CNT_W-1. Tick counters are CNT_W+1 bits to cover W+1.
- Glitch-free output: ppt_out is a direct flop, never combinational.

Optional Feature:
- Macro: PPT_INHIBIT_EN.
- Defined: adds input `inhibit` (1 bit, active-high safety interlock).
  - While inhibit=1 in FIRE/WAIT: ppt_out is forced 0 and the prescaler and tick counters freeze.
  - When inhibit releases, the sequence resumes exactly where it stopped. In FIRE, ppt_out re-asserts the next cycle.
  - Inhibit in IDLE blocks start.
- Undefined: no `inhibit` port; behaviour as above.

Decomposition:
- Shared package ppt_pkg: state enum (IDLE, FIRE, WAIT, DONE), CNT_W default, CLK_DIV_MAX=30.
- Sub-module ppt_prescaler: inputs clk, rst, clr, en, clk_div; output tick.

Test Plan:
- Reset then run_ppt=1 with clk_div=0, period=4, width=1, count=3:
  - ppt_out high 2 clks, low 6 clks, three times;
  - done=1 at 24 clks after the first pulse rise;
  - count_done=3.
- Mid-run abort with count=16: drop run_ppt after the 2nd pulse → ppt_out=0 next cycle, count_done=2, done=0, state IDLE.
- Boundary values:
  - count=0 → done=1 the cycle after start, no pulse.
  - width=0, period=0 → 1-tick high / 1-tick low pulses.
  - width=5, period=3 → 5 ticks high, 1 tick low.
- Done handshake: hold run_ppt=1 after done → stays DONE, no re-fire; release run_ppt → done=0; re-assert → count_done clears and firing restarts.
- Config isolation: change period from 4 to 8 mid-sequence → timing unchanged until restart. Also check clk_div=31 behaves as 30.
- PPT_INHIBIT_EN: assert inhibit for 10 clks mid-FIRE → ppt_out=0 during inhibit; the remaining high time is preserved after release; total count unchanged.
